// File: rtl/true_count_calc.sv
// True-count calculator: turns the counter's running count into a count per 52 cards
// remaining, using a sequential restoring divider, and derives a clamped bet suggestion.
module true_count_calc #(
  parameter int unsigned DECK_CARDS = 52,
  parameter int unsigned MAX_BET    = 8,
  parameter int unsigned DIV_W      = 22
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         deck,
  input  logic [15:0]        total,
  input  logic signed [15:0] offset,
  output logic signed [15:0] true_count,
  output logic [3:0]         bet_units,
  output logic               valid,
  output logic               busy,
  output logic               rem_err
);

  localparam int unsigned CNT_W = $clog2(DIV_W);

  typedef enum logic [1:0] {StIdle, StPrep, StCalc, StDone} state_e;

  state_e             state_q, state_d;
  logic [7:0]         snap_deck_q, snap_deck_d;
  logic [15:0]        snap_total_q, snap_total_d;
  logic [15:0]        snap_offset_q, snap_offset_d;
  logic               have_snap_q, have_snap_d;
  logic [15:0]        div_q, div_d;
  logic [15:0]        part_q, part_d;
  logic [DIV_W-1:0]   dvd_q, dvd_d;
  logic [DIV_W-1:0]   quo_q, quo_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sign_q, sign_d;
  logic               err_q, err_d;
  logic [15:0]        tc_q, tc_d;
  logic [3:0]         bet_q, bet_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               rem_err_q, rem_err_d;

  logic               diff_live;
  logic               changed;
  logic [16:0]        rem17;
  logic               rem_nonpos;
  logic [16:0]        off_ext;
  logic [16:0]        off_mag;
  logic [DIV_W-1:0]   dividend;
  logic [16:0]        part_shift;
  logic               part_ge;
  logic [14:0]        mag_sat;
  logic [15:0]        tc_abs;
  logic [15:0]        tc_new;
  logic [15:0]        tc_m1;
  logic [3:0]         bet_new;

  // Change detection and PREP/DONE arithmetic on the snapshot.
  always_comb begin
    diff_live  = (deck != snap_deck_q) || (total != snap_total_q) ||
                 (offset != snap_offset_q);
    changed    = !have_snap_q || diff_live;
    // Remaining cards in 17-bit two's complement; sign bit flags an over-dealt shoe.
    rem17      = 17'(DECK_CARDS) * {9'b0, snap_deck_q} - {1'b0, snap_total_q};
    rem_nonpos = rem17[16] || (rem17 == 17'd0);
    off_ext    = {snap_offset_q[15], snap_offset_q};
    off_mag    = off_ext[16] ? (17'd0 - off_ext) : off_ext;
    dividend   = DIV_W'(off_mag) * DIV_W'(DECK_CARDS);
    part_shift = {part_q, dvd_q[DIV_W-1]};
    part_ge    = part_shift >= {1'b0, div_q};
    mag_sat    = (quo_q > DIV_W'(32767)) ? 15'h7fff : quo_q[14:0];
    tc_abs     = {1'b0, mag_sat};
    tc_new     = sign_q ? (16'd0 - tc_abs) : tc_abs;
    tc_m1      = tc_new - 16'd1;
    if ($signed(tc_new) <= 16'sd1) begin
      bet_new = 4'd0;
    end else if ($signed(tc_m1) >= $signed(16'(MAX_BET))) begin
      bet_new = 4'(MAX_BET);
    end else begin
      bet_new = tc_m1[3:0];
    end
  end

  // Next-state logic for the FSM, divider datapath and published outputs.
  always_comb begin
    state_d       = state_q;
    snap_deck_d   = snap_deck_q;
    snap_total_d  = snap_total_q;
    snap_offset_d = snap_offset_q;
    have_snap_d   = have_snap_q;
    div_d         = div_q;
    part_d        = part_q;
    dvd_d         = dvd_q;
    quo_d         = quo_q;
    cnt_d         = cnt_q;
    sign_d        = sign_q;
    err_d         = err_q;
    tc_d          = tc_q;
    bet_d         = bet_q;
    valid_d       = valid_q;
    busy_d        = busy_q;
    rem_err_d     = rem_err_q;
    case (state_q)
      StIdle: begin
        if (changed) begin
          snap_deck_d   = deck;
          snap_total_d  = total;
          snap_offset_d = offset;
          have_snap_d   = 1'b1;
          valid_d       = 1'b0;
          busy_d        = 1'b1;
          state_d       = StPrep;
        end
      end
      StPrep: begin
        cnt_d  = '0;
        part_d = '0;
        quo_d  = '0;
        if (rem_nonpos) begin
          err_d   = 1'b1;
          sign_d  = 1'b0;
          state_d = StDone;
        end else begin
          err_d   = 1'b0;
          sign_d  = snap_offset_q[15];
          div_d   = rem17[15:0];
          dvd_d   = dividend;
          state_d = StCalc;
        end
      end
      StCalc: begin
        if (diff_live) begin
          // Inputs moved under us: drop this result, IDLE recaptures next edge.
          state_d = StIdle;
        end else begin
          part_d = part_ge ? 16'(part_shift - {1'b0, div_q}) : part_shift[15:0];
          quo_d  = {quo_q[DIV_W-2:0], part_ge};
          dvd_d  = {dvd_q[DIV_W-2:0], 1'b0};
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(DIV_W - 1)) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        tc_d      = tc_new;
        bet_d     = bet_new;
        rem_err_d = err_q;
        valid_d   = 1'b1;
        busy_d    = 1'b0;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StIdle;
      snap_deck_q   <= '0;
      snap_total_q  <= '0;
      snap_offset_q <= '0;
      have_snap_q   <= 1'b0;
      div_q         <= '0;
      part_q        <= '0;
      dvd_q         <= '0;
      quo_q         <= '0;
      cnt_q         <= '0;
      sign_q        <= 1'b0;
      err_q         <= 1'b0;
      tc_q          <= '0;
      bet_q         <= '0;
      valid_q       <= 1'b0;
      busy_q        <= 1'b0;
      rem_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      snap_deck_q   <= snap_deck_d;
      snap_total_q  <= snap_total_d;
      snap_offset_q <= snap_offset_d;
      have_snap_q   <= have_snap_d;
      div_q         <= div_d;
      part_q        <= part_d;
      dvd_q         <= dvd_d;
      quo_q         <= quo_d;
      cnt_q         <= cnt_d;
      sign_q        <= sign_d;
      err_q         <= err_d;
      tc_q          <= tc_d;
      bet_q         <= bet_d;
      valid_q       <= valid_d;
      busy_q        <= busy_d;
      rem_err_q     <= rem_err_d;
    end
  end

  assign true_count = tc_q;
  assign bet_units  = bet_q;
  assign valid      = valid_q;
  assign busy       = busy_q;
  assign rem_err    = rem_err_q;

endmodule

// File: tb/tb_true_count_calc.sv
// Scoreboard bench for true_count_calc: stimulus pushes model results, a monitor checks
// each published result (value, bet, error flag and publish cycle).
module tb_true_count_calc;

  logic               clk;
  logic               rst;
  logic [7:0]         deck;
  logic [15:0]        total;
  logic signed [15:0] offset;
  logic signed [15:0] true_count;
  logic [3:0]         bet_units;
  logic               valid;
  logic               busy;
  logic               rem_err;

  true_count_calc dut (
    .clk        (clk),
    .rst        (rst),
    .deck       (deck),
    .total      (total),
    .offset     (offset),
    .true_count (true_count),
    .bet_units  (bet_units),
    .valid      (valid),
    .busy       (busy),
    .rem_err    (rem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic signed [15:0] tc;
    logic [3:0]         bet;
    logic               err;
    int unsigned        at;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   last_tc  = 0;

  task automatic check(input string name, input longint act, input longint req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: true count = trunc(offset * 52 / (52*deck - total)), saturated to +-32767.
  function automatic exp_t model(input int d, input int t, input int o, input int unsigned cap);
    exp_t e;
    int   rem;
    int   mag;
    int   q;
    int   tc;
    rem = 52 * d - t;
    if (rem <= 0) begin
      e.tc  = 16'sd0;
      e.bet = 4'd0;
      e.err = 1'b1;
      e.at  = cap + 2;
    end else begin
      mag = (o < 0) ? -o : o;
      q   = (mag * 52) / rem;
      if (q > 32767) q = 32767;
      tc    = (o < 0) ? -q : q;
      e.tc  = 16'(tc);
      e.bet = (tc <= 1) ? 4'd0 : ((tc - 1 >= 8) ? 4'd8 : 4'(tc - 1));
      e.err = 1'b0;
      e.at  = cap + 24;
    end
    return e;
  endfunction

  // Monitor: every rising edge of valid must match the oldest expectation.
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      prev_valid <= 1'b0;
    end else begin
      if (valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_publish", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("true_count", true_count, e.tc);
          check("bet_units", bet_units, e.bet);
          check("rem_err", rem_err, e.err);
          check("publish_cycle", cyc, e.at);
          check("busy_at_publish", busy, 0);
        end
      end
      prev_valid <= valid;
    end
  end

  task automatic apply(input int d, input int t, input int o);
    exp_t e;
    @(negedge clk);
    deck   = 8'(d);
    total  = 16'(t);
    offset = 16'(o);
    e = model(d, t, o, cyc + 1);
    last_tc = e.tc;
    exp_q.push_back(e);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) return;
    end
    check("publish_timeout", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int               busy_cycles;
    bit               seen;
    int               d;
    int               t;
    int               o;
    int               ld;
    int               lt;
    int               lo;
    logic signed [15:0] r16;
    exp_t             e;

    rst    = 1'b1;
    deck   = 8'd1;
    total  = 16'd0;
    offset = 16'sd0;
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_true_count", true_count, 0);
    check("reset_bet_units", bet_units, 0);
    check("reset_valid", valid, 0);
    check("reset_busy", busy, 0);
    check("reset_rem_err", rem_err, 0);

    // First computation is forced by the empty snapshot.
    @(negedge clk);
    rst = 1'b1;
    exp_q.push_back(model(1, 0, 0, cyc + 1));
    busy_cycles = 0;
    seen        = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy) begin
        busy_cycles++;
        seen = 1'b1;
      end else if (seen) begin
        break;
      end
    end
    check("busy_cycles", busy_cycles, 24);
    wait_done();

    apply(2, 52, 10);      wait_done();
    apply(1, 26, -5);      wait_done();
    apply(1, 1, -1);       wait_done();
    apply(1, 52, 3);       wait_done();
    apply(255, 13259, 1000); wait_done();

    // Reset in the middle of CALC clears outputs immediately.
    apply(1, 0, 7);
    repeat (12) @(negedge clk);
    rst = 1'b0;
    #1;
    check("midreset_true_count", true_count, 0);
    check("midreset_bet_units", bet_units, 0);
    check("midreset_valid", valid, 0);
    check("midreset_busy", busy, 0);
    check("midreset_rem_err", rem_err, 0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    e = model(1, 0, 7, cyc + 1);
    last_tc = e.tc;
    exp_q.push_back(e);
    wait_done();

    // Abort: offset 5 is superseded mid-CALC, only 6 may be published.
    @(negedge clk);
    offset = 16'sd5;
    repeat (3) @(negedge clk);
    check("hold_true_count", true_count, last_tc);
    check("hold_valid", valid, 0);
    repeat (8) @(negedge clk);
    @(negedge clk);
    offset = 16'sd6;
    e = model(1, 0, 6, cyc + 2);
    last_tc = e.tc;
    exp_q.push_back(e);
    wait_done();

    ld = 1; lt = 0; lo = 6;
    for (int k = 0; k < 20; k++) begin
      d = $urandom_range(1, 6);
      t = $urandom_range(0, 52 * d + 10);
      if ($urandom_range(0, 4) == 0) begin
        r16 = 16'($urandom);
        o   = r16;
      end else begin
        o = $urandom_range(0, 800);
        o = o - 400;
      end
      if (d == ld && t == lt && o == lo) t = t ^ 1;
      apply(d, t, o);
      wait_done();
      ld = d; lt = t; lo = o;
    end

    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
